// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-port shared memory.
// Each granted access takes one ACCESS cycle followed by one ACK cycle.
// When both ports request at once, the port that did not win last time is granted.
module mem_arbiter #(
    parameter int unsigned N     = 32,
    parameter int unsigned Depth = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         if_req,
    input  logic [N-1:0] if_addr,
    output logic         if_ack,
    output logic [N-1:0] if_rdata,
    input  logic         d_req,
    input  logic         d_we,
    input  logic [N-1:0] d_addr,
    input  logic [N-1:0] d_wdata,
    output logic         d_ack,
    output logic [N-1:0] d_rdata,
    output logic         err,
    output logic [N-1:0] mem_address,
    output logic [N-1:0] mem_data_in,
    output logic         mem_we,
    output logic         mem_re,
    input  logic [N-1:0] mem_data_out
);

    localparam logic [N-1:0] DEPTH_N = N'(Depth);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic         r_last_d, w_last_d_nxt;       // 1: data port won the last grant
    logic         r_win_d, w_win_d_nxt;         // 1: current transaction belongs to data port
    logic         r_in_range, w_in_range_nxt;
    logic [N-1:0] r_mem_address, w_mem_address_nxt;
    logic [N-1:0] r_mem_data_in, w_mem_data_in_nxt;
    logic         r_mem_we, w_mem_we_nxt;
    logic         r_mem_re, w_mem_re_nxt;
    logic         r_if_ack, w_if_ack_nxt;
    logic         r_d_ack, w_d_ack_nxt;
    logic         r_err, w_err_nxt;
    logic [N-1:0] r_if_rdata, w_if_rdata_nxt;
    logic [N-1:0] r_d_rdata, w_d_rdata_nxt;

    logic         w_grant_d;
    logic [N-1:0] w_req_addr;
    logic         w_req_in_range;
    logic         w_req_store;
    logic [N-1:0] w_rd;

    // Round-robin pick between the two ports and the granted request's attributes
    always_comb begin
        w_grant_d      = d_req && (!if_req || !r_last_d);
        w_req_addr     = w_grant_d ? d_addr : if_addr;
        w_req_in_range = (w_req_addr < DEPTH_N);
        w_req_store    = w_grant_d && d_we;
        w_rd           = r_in_range ? mem_data_out : '0;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_last_d_nxt      = r_last_d;
        w_win_d_nxt       = r_win_d;
        w_in_range_nxt    = r_in_range;
        w_mem_address_nxt = r_mem_address;
        w_mem_data_in_nxt = r_mem_data_in;
        w_mem_we_nxt      = 1'b0;
        w_mem_re_nxt      = 1'b0;
        w_if_ack_nxt      = 1'b0;
        w_d_ack_nxt       = 1'b0;
        w_err_nxt         = 1'b0;
        w_if_rdata_nxt    = r_if_rdata;
        w_d_rdata_nxt     = r_d_rdata;

        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    w_state_nxt       = ACCESS;
                    w_last_d_nxt      = w_grant_d;
                    w_win_d_nxt       = w_grant_d;
                    w_in_range_nxt    = w_req_in_range;
                    w_mem_address_nxt = w_req_addr;
                    if (w_req_store) begin
                        w_mem_data_in_nxt = d_wdata;
                    end
                    w_mem_re_nxt      = w_req_in_range;
                    w_mem_we_nxt      = w_req_in_range && w_req_store;
                end
            end
            ACCESS: begin
                w_state_nxt = ACK;
                w_err_nxt   = !r_in_range;
                if (r_win_d) begin
                    w_d_rdata_nxt = w_rd;
                    w_d_ack_nxt   = 1'b1;
                end else begin
                    w_if_rdata_nxt = w_rd;
                    w_if_ack_nxt   = 1'b1;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_d      <= 1'b1;
            r_win_d       <= 1'b0;
            r_in_range    <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_err         <= 1'b0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_d      <= w_last_d_nxt;
            r_win_d       <= w_win_d_nxt;
            r_in_range    <= w_in_range_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_data_in <= w_mem_data_in_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_re      <= w_mem_re_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_d_ack       <= w_d_ack_nxt;
            r_err         <= w_err_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign d_ack       = r_d_ack;
    assign d_rdata     = r_d_rdata;
    assign err         = r_err;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_we      = r_mem_we;
    assign mem_re      = r_mem_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transaction table, reset-abort and conflict
// sequences, then random traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         if_req;
    logic [N-1:0] if_addr;
    logic         if_ack;
    logic [N-1:0] if_rdata;
    logic         d_req;
    logic         d_we;
    logic [N-1:0] d_addr;
    logic [N-1:0] d_wdata;
    logic         d_ack;
    logic [N-1:0] d_rdata;
    logic         err;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_data_in;
    logic         mem_we;
    logic         mem_re;
    logic [N-1:0] mem_data_out;

    mem_arbiter #(.N(N), .Depth(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .if_rdata     (if_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ack        (d_ack),
        .d_rdata      (d_rdata),
        .err          (err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Shared memory: combinational read, write on posedge
    logic [N-1:0] mem     [DEPTH];
    logic [N-1:0] ref_mem [DEPTH];

    assign mem_data_out = (mem_address < N'(DEPTH)) ? mem[mem_address[4:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_address[4:0]] <= mem_data_in;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit           is_d;
        bit           we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        bit           chk_rd;
        logic [N-1:0] exp_rd;
        bit           scramble;
    } vec_t;

    function automatic vec_t mk(input bit is_d, input bit we, input logic [N-1:0] addr,
                                input logic [N-1:0] wdata, input bit chk_rd,
                                input logic [N-1:0] exp_rd, input bit scramble);
        vec_t v;
        v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.scramble = scramble;
        return v;
    endfunction

    vec_t tbl [11];

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 32'({if_ack, d_ack, err, mem_we, mem_re}), 32'd0);
        chk("reset_mem_address", mem_address, '0);
        chk("reset_mem_data_in", mem_data_in, '0);
        chk("reset_if_rdata", if_rdata, '0);
        chk("reset_d_rdata", d_rdata, '0);
        rst_n = 1'b1;
    endtask

    // One isolated transaction: grant at the next edge, ACCESS, then ACK
    task automatic do_txn(input vec_t v);
        bit inr;
        bit st;
        inr = (v.addr < N'(DEPTH));
        st  = v.is_d && v.we;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(posedge clk); #1;
        chk("access_strobes", 32'({if_ack, d_ack, err, mem_we, mem_re}),
            32'({3'b000, inr && st, inr}));
        chk("access_addr", mem_address, v.addr);
        if (st && inr) chk("access_wdata", mem_data_in, v.wdata);
        if (v.scramble) begin
            d_addr = ~v.addr; d_we = ~v.we; d_wdata = $urandom; if_addr = $urandom;
        end
        @(posedge clk); #1;
        chk("ack_strobes", 32'({if_ack, d_ack, err, mem_we, mem_re}),
            32'({!v.is_d, v.is_d, !inr, 2'b00}));
        if (v.chk_rd) chk("ack_rdata", v.is_d ? d_rdata : if_rdata, v.exp_rd);
        if (st && inr) ref_mem[v.addr[4:0]] = v.wdata;
        @(posedge clk); #1;
        chk("post_ack_idle", 32'({if_ack, d_ack, err, mem_we, mem_re}), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
    endtask

    // Random-phase model variables
    int           cyc, free_at, g_cyc;
    bit           last_d, g_d, g_re, g_we, g_err, g_chk, acc, ackc, inr_m, st_m;
    bit           if_pend, d_pend, if_done, d_done;
    logic [N-1:0] g_addr, g_rd;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]     <= 32'h1000_0000 + 32'(i);
            ref_mem[i]  = 32'h1000_0000 + 32'(i);
        end
        mem[0]     <= 32'h0022_1820;
        ref_mem[0]  = 32'h0022_1820;

        tbl[0]  = mk(1'b0, 1'b0, 32'd0,  32'd0,          1'b1, 32'h0022_1820, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 32'd9,  32'hDEAD_BEEF,  1'b0, 32'd0,         1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 32'd9,  32'd0,          1'b1, 32'hDEAD_BEEF, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 32'd40, 32'h5555_AAAA,  1'b1, 32'd0,         1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 32'd40, 32'd0,          1'b1, 32'd0,         1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 32'd31, 32'd0,          1'b1, 32'h1000_001F, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 32'd32, 32'd0,          1'b1, 32'd0,         1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 32'd31, 32'h1234_5678,  1'b0, 32'd0,         1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 32'd31, 32'd0,          1'b1, 32'h1234_5678, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 32'd9,  32'd0,          1'b1, 32'hDEAD_BEEF, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 32'd0,  32'd0,          1'b1, 32'h0022_1820, 1'b0);

        do_reset();
        @(posedge clk); #1;

        foreach (tbl[i]) do_txn(tbl[i]);

        // Reset in the ACCESS cycle of a store aborts it
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("abort_pre_we", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({if_ack, d_ack, err, mem_we, mem_re}), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_no_ack", 32'({if_ack, d_ack, err, mem_we, mem_re}), 32'd0);
        end

        // Continuous conflict: fetch wins first, then strict alternation every 3 cycles
        if_req = 1'b1; if_addr = 32'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd9;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk("conflict_acks", 32'({if_ack, d_ack}),
                32'({(k == 2) || (k == 8), (k == 5) || (k == 11)}));
            if (k == 2 || k == 8) chk("conflict_if_rdata", if_rdata, 32'h0022_1820);
            if (k == 5 || k == 11) chk("conflict_d_rdata", d_rdata, 32'hDEAD_BEEF);
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;

        // Random traffic against a transaction-level model
        do_reset();
        last_d = 1'b1; free_at = 0; g_cyc = -100;
        if_pend = 1'b0; d_pend = 1'b0; if_done = 1'b0; d_done = 1'b0;
        g_d = 1'b0; g_re = 1'b0; g_we = 1'b0; g_err = 1'b0; g_chk = 1'b0;
        g_addr = '0; g_rd = '0;
        for (cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            acc  = (cyc == g_cyc + 1);
            ackc = (cyc == g_cyc + 2);
            chk("rnd_strobes", 32'({if_ack, d_ack, err, mem_we, mem_re}),
                32'({ackc && !g_d, ackc && g_d, ackc && g_err, acc && g_we, acc && g_re}));
            if (acc) chk("rnd_addr", mem_address, g_addr);
            if (ackc && g_chk) chk("rnd_rdata", g_d ? d_rdata : if_rdata, g_rd);

            // Requesters hold req through the ack cycle and drop it the cycle after
            if (if_done) begin if_pend = 1'b0; if_done = 1'b0; end
            if (d_done)  begin d_pend  = 1'b0; d_done  = 1'b0; end
            if (ackc) begin
                if (g_d) d_done = 1'b1; else if_done = 1'b1;
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1; if_addr = 32'($urandom_range(0, 39));
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1; d_we = ($urandom_range(0, 1) == 1);
                d_addr = 32'($urandom_range(0, 39)); d_wdata = $urandom;
            end
            if_req = if_pend;
            d_req  = d_pend;

            // Grant decision taken at the next edge
            if (cyc >= free_at && (if_pend || d_pend)) begin
                if (if_pend && d_pend) g_d = !last_d;
                else                   g_d = d_pend;
                last_d  = g_d;
                g_cyc   = cyc;
                free_at = cyc + 3;
                g_addr  = g_d ? d_addr : if_addr;
                inr_m   = (g_addr < N'(DEPTH));
                st_m    = g_d && d_we;
                g_re    = inr_m;
                g_we    = inr_m && st_m;
                g_err   = !inr_m;
                g_chk   = !st_m || !inr_m;
                g_rd    = inr_m ? ref_mem[g_addr[4:0]] : '0;
                if (g_we) ref_mem[g_addr[4:0]] = d_wdata;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N, default 32: data and address width.
REQ-002 Parameter Depth, default 32: number of words in the shared memory; the legal address range is 0..Depth-1.
REQ-003 clk  in  1: single clock; all state updates on posedge.
REQ-004 rst_n  in  1: reset; one clock, reset asynchronous and active-low.
REQ-005 if_req  in  1: instruction-fetch read request, held until if_ack.
REQ-006 if_addr  in  N: fetch word address.
REQ-007 if_ack  out  1: one-cycle pulse; fetch complete.
REQ-008 if_rdata  out  N: fetched word, valid while if_ack=1.
REQ-009 d_req  in  1: data-port request, held until d_ack.
REQ-010 d_we  in  1: 1=store, 0=load.
REQ-011 d_addr  in  N: data word address.
REQ-012 d_wdata  in  N: store data.
REQ-013 d_ack  out  1: one-cycle pulse; data access complete.
REQ-014 d_rdata  out  N: load data, valid while d_ack=1.
REQ-015 err  out  1: one-cycle pulse coincident with the ack when the address was >= Depth.
REQ-016 mem_address  out  N: to the shared memory address input.
REQ-017 mem_data_in  out  N: to the memory write-data input.
REQ-018 mem_we  out  1: to the memory write enable.
REQ-019 mem_re  out  1: to the memory read enable.
REQ-020 mem_data_out  in  N: combinational read data from the memory.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS and ACK.
REQ-022 IDLE with no requests SHALL remain in IDLE.
REQ-023 IDLE with any request SHALL go to ACCESS, latching the winner, address, we and wdata into internal registers; a fetch is always a read.
REQ-024 Arbitration with a single requester SHALL grant that requester.
REQ-025 Arbitration with both if_req=1 and d_req=1 SHALL be round-robin: grant the port not recorded in last_grant; last_grant is updated on every grant.
REQ-026 ACCESS SHALL drive mem_address from the latched address and mem_re=1, and assert mem_we=1 only for an in-range data store, so the memory writes at the posedge ending ACCESS.
REQ-027 ACCESS SHALL capture mem_data_out into the winner's rdata register at the posedge ending ACCESS, then go to ACK.
REQ-028 ACK SHALL pulse exactly one of if_ack/d_ack for one cycle, then return to IDLE.
REQ-029 Latency SHALL be: request sampled in IDLE at cycle t -> ACCESS at t+1 -> ack at t+2; the next grant occurs no earlier than t+3.
REQ-030 Requests SHALL be ignored in ACCESS and ACK; a requester deasserts req in the cycle after its ack.
REQ-031 For an out-of-range access (latched address >= Depth): no write, mem_re=0, rdata=0, err=1 during ACK.
REQ-032 Outside ACCESS, mem_we and mem_re SHALL be 0, and mem_address and mem_data_in SHALL hold their last values.
REQ-033 if_rdata and d_rdata SHALL hold their values until that port's next capture.
REQ-034 Input changes during ACCESS or ACK SHALL not affect the latched transaction.

Reset
REQ-035 While rst_n=0 (asynchronous, immediate): state=IDLE, last_grant=data (fetch wins the first conflict), all ack/err/mem_we/mem_re=0, mem_address=0, mem_data_in=0, if_rdata=0, d_rdata=0.
REQ-036 Reset in ACCESS SHALL abort the access: mem_we drops immediately, no ack is ever issued, and the requester re-requests.

Verification
REQ-037 Fetch only: memory word 0 = 0x00221820, if_req=1, if_addr=0 at t -> if_ack=1 and if_rdata=0x00221820 at t+2; d_ack stays 0.
REQ-038 Store then load: d_we=1, d_addr=9, d_wdata=0xDEADBEEF -> mem_we=1 for one cycle at t+1, d_ack at t+2; then a load of address 9 -> d_rdata=0xDEADBEEF.
REQ-039 Conflict after reset: if_req=d_req=1 held continuously -> grants alternate fetch, data, fetch, data, with one ack every 3 cycles.
REQ-040 Out of range: d_we=1, d_addr=40 (Depth=32) -> err=1 with d_ack, mem_we never 1, memory unchanged.
REQ-041 Reset during ACCESS of a store -> mem_we=0 in the same cycle, no ack, and after reset release the FSM is in IDLE with last_grant=data.
